// File: rtl/mips_issuer.sv
// Credit-limited command issuer for a MIPS-style core: encodes commands into
// instruction words, tracks in-flight work and buffers returned results in a FIFO.
module mips_issuer #(
   parameter int CREDITS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [2:0]   cmd_op,
   input  logic [2:0]   cmd_rs,
   input  logic [2:0]   cmd_rt,
   input  logic [2:0]   cmd_rd,
   input  logic [4:0]   cmd_shamt,
   input  logic [15:0]  cmd_imm,
   input  logic [11:0]  cmd_osel,
   output logic         in_valid,
   output logic [31:0]  instruction,
   output logic [19:0]  output_reg,
   input  logic         out_valid,
   input  logic [31:0]  out_1,
   input  logic [31:0]  out_2,
   input  logic [31:0]  out_3,
   input  logic [31:0]  out_4,
   input  logic         instruction_fail,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [127:0] res_data,
   output logic         res_fail,
   input  logic         flush,
   output logic         flush_done,
   output logic         err_unexp
);

   typedef enum logic [1:0] {IDLE, ISSUE, STALL, DRAIN} state_t;

   localparam logic [3:0] CRED4 = 4'(CREDITS);
   localparam logic [2:0] CRED3 = 3'(CREDITS);
   localparam logic [1:0] LAST_PTR = 2'(CREDITS - 1);

   state_t       state_q, state_d;
   logic [2:0]   inflight_q, inflight_d;
   logic [2:0]   fifo_cnt_q, fifo_cnt_d;
   logic [1:0]   wr_ptr_q, wr_ptr_d;
   logic [1:0]   rd_ptr_q, rd_ptr_d;
   logic [128:0] mem_q [CREDITS];
   logic         rdy_en_q;
   logic         in_valid_q, in_valid_d;
   logic [31:0]  instruction_q, instruction_d;
   logic [19:0]  output_reg_q, output_reg_d;
   logic         err_unexp_q, err_unexp_d;

   logic [31:0]  enc;
   logic [19:0]  oreg;
   logic [5:0]   funct;
   logic [4:0]   shamt_f;
   logic         credit_ok, accept, ov_ok, fifo_full, pop, push;
   logic [3:0]   sum_next;
   logic [128:0] head;

   function automatic logic [4:0] map_reg(input logic [2:0] idx);
      logic [4:0] a;
      case (idx)
         3'd0:    a = 5'b10000;
         3'd1:    a = 5'b11111;
         3'd2:    a = 5'b10111;
         3'd3:    a = 5'b01000;
         3'd4:    a = 5'b10010;
         3'd5:    a = 5'b10001;
         default: a = 5'b00000;
      endcase
      return a;
   endfunction

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
   endfunction

   always_comb begin
      funct = 6'b000000;
      case (cmd_op)
         3'd0:    funct = 6'b100000;
         3'd1:    funct = 6'b100100;
         3'd2:    funct = 6'b100101;
         3'd3:    funct = 6'b100111;
         3'd5:    funct = 6'b000010;
         default: funct = 6'b000000;
      endcase
      shamt_f = (cmd_op == 3'd4 || cmd_op == 3'd5) ? cmd_shamt : 5'd0;
      if (cmd_op == 3'd6) begin
         enc = {6'b001000, map_reg(cmd_rs), map_reg(cmd_rd), cmd_imm};
      end else begin
         enc = {(cmd_op == 3'd7) ? 6'b111111 : 6'b000000, map_reg(cmd_rs),
                map_reg(cmd_rt), map_reg(cmd_rd), shamt_f, funct};
      end
      oreg = {map_reg(cmd_osel[11:9]), map_reg(cmd_osel[8:6]),
              map_reg(cmd_osel[5:3]), map_reg(cmd_osel[2:0])};
   end

   // Credits cover both work in the core and results still sitting in the FIFO.
   always_comb begin
      credit_ok  = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < CRED4;
      cmd_ready  = rdy_en_q && (state_q != DRAIN) && !flush && credit_ok;
      accept     = cmd_valid && cmd_ready;
      ov_ok      = out_valid && (inflight_q != 3'd0);
      fifo_full  = (fifo_cnt_q == CRED3);
      res_valid  = (fifo_cnt_q != 3'd0);
      pop        = res_valid && res_ready;
      push       = ov_ok && (!fifo_full || pop);
      head       = mem_q[rd_ptr_q];
      res_data   = res_valid ? head[128:1] : 128'd0;
      res_fail   = res_valid && head[0];

      inflight_d = inflight_q + 3'(accept) - 3'(ov_ok);
      fifo_cnt_d = fifo_cnt_q + 3'(push) - 3'(pop);
      wr_ptr_d   = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
      sum_next   = {1'b0, inflight_d} + {1'b0, fifo_cnt_d};

      in_valid_d    = accept;
      instruction_d = accept ? enc : 32'd0;
      output_reg_d  = accept ? oreg : 20'd0;
      err_unexp_d   = err_unexp_q || (out_valid && (inflight_q == 3'd0));
   end

   always_comb begin
      state_d    = state_q;
      flush_done = 1'b0;
      case (state_q)
         DRAIN: begin
            if (inflight_q == 3'd0) begin
               flush_done = 1'b1;
               state_d    = (sum_next < CRED4) ? IDLE : STALL;
            end
         end
         default: begin
            if (flush) begin
               state_d = DRAIN;
            end else if (accept) begin
               state_d = ISSUE;
            end else if (sum_next >= CRED4) begin
               state_d = STALL;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         inflight_q    <= 3'd0;
         fifo_cnt_q    <= 3'd0;
         wr_ptr_q      <= 2'd0;
         rd_ptr_q      <= 2'd0;
         rdy_en_q      <= 1'b0;
         in_valid_q    <= 1'b0;
         instruction_q <= 32'd0;
         output_reg_q  <= 20'd0;
         err_unexp_q   <= 1'b0;
         for (int i = 0; i < CREDITS; i++) mem_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         inflight_q    <= inflight_d;
         fifo_cnt_q    <= fifo_cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         rdy_en_q      <= 1'b1;
         in_valid_q    <= in_valid_d;
         instruction_q <= instruction_d;
         output_reg_q  <= output_reg_d;
         err_unexp_q   <= err_unexp_d;
         if (push) mem_q[wr_ptr_q] <= {out_4, out_3, out_2, out_1, instruction_fail};
      end
   end

   // A result arriving into a full FIFO would mean the credit accounting is broken.
   always @(posedge clk) begin
      assert (!(ov_ok && fifo_full && !pop));
   end

   assign in_valid    = in_valid_q;
   assign instruction = instruction_q;
   assign output_reg  = output_reg_q;
   assign err_unexp   = err_unexp_q;

endmodule

// File: tb/tb_mips_issuer.sv
// Directed bench for mips_issuer: a queue-based reference model checked every
// cycle, a 3-cycle core responder, and literal checks on the key scenarios.
module tb_mips_issuer;
   localparam int CREDITS = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid, cmd_ready;
   logic [2:0]   cmd_op, cmd_rs, cmd_rt, cmd_rd;
   logic [4:0]   cmd_shamt;
   logic [15:0]  cmd_imm;
   logic [11:0]  cmd_osel;
   logic         in_valid;
   logic [31:0]  instruction;
   logic [19:0]  output_reg;
   logic         out_valid;
   logic [31:0]  out_1, out_2, out_3, out_4;
   logic         instruction_fail;
   logic         res_valid, res_ready, res_fail;
   logic [127:0] res_data;
   logic         flush, flush_done, err_unexp;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   mips_issuer #(.CREDITS(CREDITS)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
      .cmd_shamt(cmd_shamt), .cmd_imm(cmd_imm), .cmd_osel(cmd_osel),
      .in_valid(in_valid), .instruction(instruction), .output_reg(output_reg),
      .out_valid(out_valid), .out_1(out_1), .out_2(out_2), .out_3(out_3), .out_4(out_4),
      .instruction_fail(instruction_fail),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_fail(res_fail),
      .flush(flush), .flush_done(flush_done), .err_unexp(err_unexp)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   localparam logic [4:0] ADDR_TBL [8] = '{5'b10000, 5'b11111, 5'b10111, 5'b01000,
                                          5'b10010, 5'b10001, 5'b00000, 5'b00000};
   localparam logic [5:0] FUNCT_TBL [8] = '{6'h20, 6'h24, 6'h25, 6'h27,
                                           6'h00, 6'h02, 6'h00, 6'h00};

   function automatic logic [31:0] ref_instr(input logic [2:0] op, input logic [2:0] rs,
                                             input logic [2:0] rt, input logic [2:0] rd,
                                             input logic [4:0] sh, input logic [15:0] imm);
      if (op == 3'd6) return {6'h08, ADDR_TBL[rs], ADDR_TBL[rd], imm};
      return {(op == 3'd7) ? 6'h3f : 6'h00, ADDR_TBL[rs], ADDR_TBL[rt], ADDR_TBL[rd],
              (op == 3'd4 || op == 3'd5) ? sh : 5'd0, FUNCT_TBL[op]};
   endfunction

   function automatic logic [19:0] ref_oreg(input logic [11:0] osel);
      logic [19:0] r;
      for (int i = 0; i < 4; i++) r[5*i +: 5] = ADDR_TBL[osel[3*i +: 3]];
      return r;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: counts and a result queue, updated on each clock edge.
   int           m_inflight;
   logic [128:0] m_fifo [$];
   bit           m_drain, m_err, m_alive, m_iv;
   logic [31:0]  m_instr;
   logic [19:0]  m_oreg;

   function automatic bit m_ready();
      return m_alive && !m_drain && !flush && (m_inflight + m_fifo.size() < CREDITS);
   endfunction

   always @(posedge clk or posedge rst) begin
      bit acc;
      int old_inflight;
      if (rst) begin
         m_inflight = 0;
         m_fifo.delete();
         m_drain = 0; m_err = 0; m_alive = 0; m_iv = 0;
         m_instr = '0; m_oreg = '0;
      end else begin
         acc = cmd_valid && m_ready();
         old_inflight = m_inflight;
         if (m_fifo.size() > 0 && res_ready) void'(m_fifo.pop_front());
         if (out_valid) begin
            if (old_inflight == 0) m_err = 1;
            else begin
               m_inflight--;
               m_fifo.push_back({out_4, out_3, out_2, out_1, instruction_fail});
               check("fifo_not_overfilled", 128'(m_fifo.size() <= CREDITS), 128'd1);
            end
         end
         if (acc) m_inflight++;
         if (m_drain) begin
            if (old_inflight == 0) m_drain = 0;
         end else if (flush) m_drain = 1;
         m_iv    = acc;
         m_instr = acc ? ref_instr(cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_imm) : 32'd0;
         m_oreg  = acc ? ref_oreg(cmd_osel) : 20'd0;
         m_alive = 1;
      end
   end

   always @(negedge clk) begin
      logic [128:0] h;
      h = (m_fifo.size() > 0) ? m_fifo[0] : 129'd0;
      check("cmd_ready", 128'(cmd_ready), 128'(m_ready()));
      check("in_valid", 128'(in_valid), 128'(m_iv));
      check("instruction", 128'(instruction), 128'(m_instr));
      check("output_reg", 128'(output_reg), 128'(m_oreg));
      check("res_valid", 128'(res_valid), 128'(m_fifo.size() > 0));
      check("res_data", res_data, h[128:1]);
      check("res_fail", 128'(res_fail), 128'(h[0]));
      check("flush_done", 128'(flush_done), 128'(m_drain && m_inflight == 0));
      check("err_unexp", 128'(err_unexp), 128'(m_err));
   end

   // Core stand-in: answers each instruction three cycles later.
   bit          pv [3];
   logic [31:0] pi [3];
   logic [19:0] po [3];
   bit          spur_req = 0;

   function automatic bit core_fail(input logic [31:0] ins, input logic [19:0] orr);
      bit f;
      f = (ins[31:26] == 6'h3f) || (ins[25:21] == 5'd0) || (ins[20:16] == 5'd0) ||
          (ins[31:26] == 6'h00 && ins[15:11] == 5'd0);
      for (int i = 0; i < 4; i++) if (orr[5*i +: 5] == 5'd0) f = 1;
      return f;
   endfunction

   always @(posedge clk) begin
      bit f;
      #1;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin pv[i] = 0; pi[i] = '0; po[i] = '0; end
         out_valid = 0; instruction_fail = 0;
         out_1 = '0; out_2 = '0; out_3 = '0; out_4 = '0;
      end else begin
         f = core_fail(pi[2], po[2]);
         out_valid        = pv[2] || spur_req;
         instruction_fail = f;
         out_1 = f ? 32'd0 : pi[2] ^ {po[2], 12'hA01};
         out_2 = f ? 32'd0 : pi[2] + {po[2], 12'hB02};
         out_3 = f ? 32'd0 : ~pi[2];
         out_4 = f ? 32'd0 : {pi[2][15:0], po[2][15:0]};
         spur_req = 0;
         pv[2] = pv[1]; pi[2] = pi[1]; po[2] = po[1];
         pv[1] = pv[0]; pi[1] = pi[0]; po[1] = po[0];
         pv[0] = in_valid; pi[0] = instruction; po[0] = output_reg;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                        input logic [2:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [11:0] osel);
      bit acc;
      bit done;
      done = 0;
      cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
      cmd_shamt = sh; cmd_imm = imm; cmd_osel = osel;
      cmd_valid = 1;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         acc = cmd_ready;
         tick();
         if (acc) done = 1;
      end
      cmd_valid = 0;
      check("issue_accepted", 128'(done), 128'd1);
   endtask

   task automatic wait_result(input string name, output int n);
      bit seen;
      seen = 0;
      n = 0;
      for (int i = 0; i < 12 && !seen; i++) begin
         @(negedge clk);
         if (res_valid) seen = 1;
         else begin tick(); n++; end
      end
      check(name, 128'(seen), 128'd1);
   endtask

   task automatic pop_one();
      res_ready = 1;
      tick();
      res_ready = 0;
   endtask

   initial begin
      int n, acc_cnt, last_ov, fd_cyc, fd_cnt, pops;
      rst = 1; cmd_valid = 0; cmd_op = 0; cmd_rs = 0; cmd_rt = 0; cmd_rd = 0;
      cmd_shamt = 0; cmd_imm = 0; cmd_osel = 0; res_ready = 0; flush = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk); check("ready_low_after_reset", 128'(cmd_ready), 128'd0);
      tick();
      @(negedge clk); check("ready_rises", 128'(cmd_ready), 128'd1);
      tick();

      // add rs=0 rt=1 rd=2 osel=0
      res_ready = 1;
      issue(3'd0, 3'd0, 3'd1, 3'd2, 5'd0, 16'd0, 12'd0);
      @(negedge clk);
      check("add_instr", 128'(instruction), 128'h021FB820);
      check("add_oreg", 128'(output_reg), 128'h84210);
      check("add_in_valid", 128'(in_valid), 128'd1);
      tick();
      @(negedge clk); check("add_in_valid_one_cycle", 128'(in_valid), 128'd0);
      tick();
      repeat (6) tick();

      // addi rs=3 rd=5 imm=5, result latency
      res_ready = 0;
      issue(3'd6, 3'd3, 3'd0, 3'd5, 5'd0, 16'h0005, 12'd0);
      @(negedge clk); check("addi_instr", 128'(instruction), 128'h21110005);
      tick();
      wait_result("addi_result", n);
      check("addi_latency", 128'(n + 1), 128'd4);
      check("addi_res_fail", 128'(res_fail), 128'd0);
      tick();
      pop_one();

      // five back-to-back commands with no reader
      cmd_valid = 1; acc_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         cmd_op = 3'(acc_cnt); cmd_rs = 3'(acc_cnt); cmd_rt = 3'(acc_cnt + 1); cmd_rd = 3'd2;
         cmd_shamt = 5'(acc_cnt + 3); cmd_imm = 16'd0; cmd_osel = 12'h123;
         @(negedge clk);
         if (cmd_ready) acc_cnt++;
         tick();
      end
      check("b2b_four_accepted", 128'(acc_cnt), 128'd4);
      @(negedge clk); check("b2b_ready_low", 128'(cmd_ready), 128'd0);
      tick();
      pop_one();
      for (int i = 0; i < 10 && acc_cnt < 5; i++) begin
         cmd_op = 3'd5; cmd_rs = 3'd4; cmd_rt = 3'd5; cmd_shamt = 5'd9;
         @(negedge clk);
         if (cmd_ready) acc_cnt++;
         tick();
      end
      cmd_valid = 0;
      check("b2b_fifth_accepted", 128'(acc_cnt), 128'd5);
      res_ready = 1;
      repeat (15) tick();
      res_ready = 0;

      // illegal op and unmapped register index
      issue(3'd7, 3'd0, 3'd1, 3'd2, 5'd7, 16'd0, 12'd0);
      wait_result("op7_result", n);
      check("op7_res_fail", 128'(res_fail), 128'd1);
      check("op7_res_data", res_data, 128'd0);
      tick();
      pop_one();
      issue(3'd0, 3'd6, 3'd1, 3'd2, 5'd0, 16'd0, 12'd0);
      wait_result("idx6_result", n);
      check("idx6_res_fail", 128'(res_fail), 128'd1);
      check("idx6_res_data", res_data, 128'd0);
      tick();
      pop_one();
      repeat (2) tick();

      // flush with three in flight
      cmd_valid = 1; acc_cnt = 0;
      cmd_op = 3'd2; cmd_rs = 3'd1; cmd_rt = 3'd3; cmd_rd = 3'd4; cmd_osel = 12'h0A5;
      for (int i = 0; i < 10 && acc_cnt < 3; i++) begin
         @(negedge clk);
         if (cmd_ready) acc_cnt++;
         tick();
      end
      cmd_valid = 0;
      flush = 1;
      @(negedge clk); check("ready_low_in_flush_cycle", 128'(cmd_ready), 128'd0);
      tick();
      flush = 0;
      last_ov = -100; fd_cyc = -200; fd_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0) check("ready_low_in_drain", 128'(cmd_ready), 128'd0);
         if (out_valid) last_ov = cyc;
         if (flush_done) begin fd_cnt++; fd_cyc = cyc; end
         tick();
      end
      check("flush_done_count", 128'(fd_cnt), 128'd1);
      check("flush_done_timing", 128'(fd_cyc - last_ov), 128'd1);
      res_ready = 1; pops = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (res_valid) pops++;
         tick();
      end
      res_ready = 0;
      check("fifo_kept_three", 128'(pops), 128'd3);

      // spurious result at idle
      spur_req = 1;
      repeat (4) tick();
      @(negedge clk);
      check("spur_err_unexp", 128'(err_unexp), 128'd1);
      check("spur_fifo_empty", 128'(res_valid), 128'd0);
      tick();

      // reset while work is in flight
      issue(3'd1, 3'd2, 3'd3, 3'd4, 5'd0, 16'd0, 12'h111);
      issue(3'd3, 3'd5, 3'd0, 3'd1, 5'd0, 16'd0, 12'h222);
      rst = 1;
      #1;
      check("rst_cmd_ready", 128'(cmd_ready), 128'd0);
      check("rst_in_valid", 128'(in_valid), 128'd0);
      check("rst_instruction", 128'(instruction), 128'd0);
      check("rst_output_reg", 128'(output_reg), 128'd0);
      check("rst_res_valid", 128'(res_valid), 128'd0);
      check("rst_res_data", res_data, 128'd0);
      check("rst_res_fail", 128'(res_fail), 128'd0);
      check("rst_flush_done", 128'(flush_done), 128'd0);
      check("rst_err_unexp", 128'(err_unexp), 128'd0);
      repeat (2) tick();
      rst = 0;
      repeat (8) tick();
      @(negedge clk);
      check("post_rst_err", 128'(err_unexp), 128'd0);
      check("post_rst_fifo", 128'(res_valid), 128'd0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
